// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-bus SRAM responder.
// FSM states and sticky protocol-error bit positions.
package data_mem_responder_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD       = 3'd1,
      S_WR_SETUP = 3'd2,
      S_WR_PULSE = 3'd3,
      S_DONE     = 3'd4
   } state_e;

   localparam int ERR_STROBE_BUSY   = 0;
   localparam int ERR_ADDR_MISMATCH = 1;

endpackage

// File: rtl/data_mem_responder.sv
// Memory-side responder for the early-strobe/stall data bus.
// Drives an asynchronous SRAM with programmable read/write wait states.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_BITS = 18,
   parameter int RD_WAIT   = 1,
   parameter int WR_WAIT   = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 Mem_EarlyStrobe,
   input  logic [31:0]          Mem_EarlyAddress,
   input  logic                 Mem_EarlyWrite,
   input  logic [31:0]          Mem_Address,
   input  logic                 Mem_Write,
   input  logic [3:0]           Mem_ByteSelect,
   input  logic [31:0]          Mem_WriteData,
   output logic [31:0]          Mem_ReadData,
   output logic                 Mem_Stall,
   output logic [ADDR_BITS-1:0] sram_addr,
   output logic [31:0]          sram_wdata,
   input  logic [31:0]          sram_rdata,
   output logic                 sram_ce,
   output logic                 sram_oe,
   output logic                 sram_we,
   output logic [3:0]           sram_be,
   output logic [1:0]           proto_err
);

   localparam logic [3:0] RdWait = 4'(RD_WAIT);
   localparam logic [3:0] WrWait = 4'(WR_WAIT);

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  ce_q, ce_d;
   logic                  oe_q, oe_d;
   logic                  we_q, we_d;
   logic [3:0]            be_q, be_d;
   logic [1:0]            err_q, err_d;

   logic                  busy;
   logic                  addr_bad;

   assign busy     = (state_q == S_RD) || (state_q == S_WR_SETUP) ||
                     (state_q == S_WR_PULSE);
   assign addr_bad = Mem_Address[ADDR_BITS+1:2] != addr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ce_d    = ce_q;
      oe_d    = oe_q;
      we_d    = we_q;
      be_d    = be_q;
      err_d   = err_q;

      if (busy && Mem_EarlyStrobe) err_d[ERR_STROBE_BUSY] = 1'b1;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            ce_d = 1'b0;
            oe_d = 1'b0;
            we_d = 1'b0;
            if (Mem_EarlyStrobe) begin
               addr_d = Mem_EarlyAddress[ADDR_BITS+1:2];
               if (Mem_EarlyWrite) begin
                  state_d = S_WR_SETUP;
               end else begin
                  state_d = S_RD;
                  cnt_d   = RdWait;
                  ce_d    = 1'b1;
                  oe_d    = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            // The counter only counts down, so its start value marks entry
            if (cnt_q == RdWait && addr_bad) err_d[ERR_ADDR_MISMATCH] = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rdata_d = sram_rdata;
               ce_d    = 1'b0;
               oe_d    = 1'b0;
               state_d = S_DONE;
            end
         end
         S_WR_SETUP: begin
            if (addr_bad) err_d[ERR_ADDR_MISMATCH] = 1'b1;
            if (Mem_Write && (Mem_ByteSelect != 4'd0)) begin
               wdata_d = Mem_WriteData;
               be_d    = Mem_ByteSelect;
               ce_d    = 1'b1;
               we_d    = 1'b1;
               cnt_d   = WrWait;
               state_d = S_WR_PULSE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_WR_PULSE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               we_d    = 1'b0;
               ce_d    = 1'b0;
               be_d    = 4'd0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         ce_q    <= 1'b0;
         oe_q    <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         err_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         be_q    <= be_d;
         err_q   <= err_d;
      end
   end

   assign Mem_ReadData = rdata_q;
   assign Mem_Stall    = busy;
   assign sram_addr    = addr_q;
   assign sram_wdata   = wdata_q;
   assign sram_ce      = ce_q;
   assign sram_oe      = oe_q;
   assign sram_we      = we_q;
   assign sram_be      = be_q;
   assign proto_err    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a behavioural SRAM.
// Inputs change and outputs are sampled on the falling edge.
module tb_data_mem_responder;

   logic        clock;
   logic        reset;
   logic        Mem_EarlyStrobe;
   logic [31:0] Mem_EarlyAddress;
   logic        Mem_EarlyWrite;
   logic [31:0] Mem_Address;
   logic        Mem_Write;
   logic [3:0]  Mem_ByteSelect;
   logic [31:0] Mem_WriteData;
   logic [31:0] Mem_ReadData;
   logic        Mem_Stall;
   logic [17:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_ce;
   logic        sram_oe;
   logic        sram_we;
   logic [3:0]  sram_be;
   logic [1:0]  proto_err;

   logic [31:0] mem [0:255];
   logic        pl_en;
   logic [7:0]  pl_idx;
   logic [31:0] pl_val;

   int n_checks;
   int n_fail;

   data_mem_responder #(.ADDR_BITS(18), .RD_WAIT(1), .WR_WAIT(1)) dut (
      .clock(clock),
      .reset(reset),
      .Mem_EarlyStrobe(Mem_EarlyStrobe),
      .Mem_EarlyAddress(Mem_EarlyAddress),
      .Mem_EarlyWrite(Mem_EarlyWrite),
      .Mem_Address(Mem_Address),
      .Mem_Write(Mem_Write),
      .Mem_ByteSelect(Mem_ByteSelect),
      .Mem_WriteData(Mem_WriteData),
      .Mem_ReadData(Mem_ReadData),
      .Mem_Stall(Mem_Stall),
      .sram_addr(sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata),
      .sram_ce(sram_ce),
      .sram_oe(sram_oe),
      .sram_we(sram_we),
      .sram_be(sram_be),
      .proto_err(proto_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign sram_rdata = (sram_ce && sram_oe) ? mem[sram_addr[7:0]] : 32'd0;

   always @(posedge clock) begin
      if (pl_en) begin
         mem[pl_idx] <= pl_val;
      end else if (sram_ce && sram_we) begin
         for (int b = 0; b < 4; b++)
            if (sram_be[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      pl_en  = 1'b1;
      pl_idx = idx;
      pl_val = val;
      @(negedge clock);
      pl_en  = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic do_access(input logic [31:0] ea, input logic [31:0] ma,
                            input logic wr, input logic cm,
                            input logic [3:0] bs, input logic [31:0] wd,
                            output int st, output int wes, output int ovl,
                            output logic [3:0] be_seen);
      st = 0; wes = 0; ovl = 0; be_seen = 4'd0;
      Mem_EarlyStrobe  = 1'b1;
      Mem_EarlyAddress = ea;
      Mem_EarlyWrite   = wr;
      @(negedge clock);
      Mem_EarlyStrobe = 1'b0;
      Mem_Address     = ma;
      Mem_Write       = cm;
      Mem_ByteSelect  = bs;
      Mem_WriteData   = wd;
      while (Mem_Stall && st < 32) begin
         st++;
         if (sram_we) begin
            wes++;
            be_seen = sram_be;
         end
         if (sram_oe && sram_we) ovl++;
         @(negedge clock);
      end
      Mem_Write      = 1'b0;
      Mem_ByteSelect = 4'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      preload(8'h10, 32'hDEADBEEF);
      preload(8'h11, 32'hCAFEF00D);
      preload(8'h12, 32'h11112222);
      preload(8'h13, 32'h00000000);
      @(negedge clock);
      reset = 1'b0;
      n_checks++;
      if ({Mem_Stall, sram_ce, sram_oe, sram_we} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000", {Mem_Stall, sram_ce, sram_oe, sram_we});
      end
      n_checks++;
      if (Mem_ReadData !== 32'd0 || sram_wdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_data: rd %h wd %h want 0", Mem_ReadData, sram_wdata);
      end
      n_checks++;
      if (sram_addr !== 18'd0 || sram_be !== 4'd0 || proto_err !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_misc: addr %h be %b err %b want 0", sram_addr, sram_be, proto_err);
      end
   endtask

   task automatic test_read();
      int st, wes, ovl;
      logic [3:0] bes;
      do_access(32'h40, 32'h40, 1'b0, 1'b0, 4'd0, 32'd0, st, wes, ovl, bes);
      n_checks++;
      if (st !== 2) begin
         n_fail++;
         $display("FAIL read_stall: got %0d want 2", st);
      end
      n_checks++;
      if (Mem_ReadData !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL read_data: got %h want deadbeef", Mem_ReadData);
      end
      n_checks++;
      if (sram_addr !== 18'h10 || sram_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL read_addr: addr %h oe %b want 10 0", sram_addr, sram_oe);
      end
   endtask

   task automatic test_write();
      int st, wes, ovl;
      logic [3:0] bes;
      do_access(32'h44, 32'h44, 1'b1, 1'b1, 4'b0011, 32'h1234ABCD, st, wes, ovl, bes);
      n_checks++;
      if (st !== 3 || wes !== 2) begin
         n_fail++;
         $display("FAIL write_timing: stall %0d we %0d want 3 2", st, wes);
      end
      n_checks++;
      if (bes !== 4'b0011 || sram_be !== 4'd0) begin
         n_fail++;
         $display("FAIL write_be: during %b after %b want 0011 0000", bes, sram_be);
      end
      do_access(32'h44, 32'h44, 1'b0, 1'b0, 4'd0, 32'd0, st, wes, ovl, bes);
      n_checks++;
      if (Mem_ReadData !== 32'hCAFEABCD) begin
         n_fail++;
         $display("FAIL write_readback: got %h want cafeabcd", Mem_ReadData);
      end
   endtask

   task automatic test_cancelled();
      int st, wes, ovl;
      logic [3:0] bes;
      do_access(32'h48, 32'h48, 1'b1, 1'b0, 4'b1111, 32'hFFFFFFFF, st, wes, ovl, bes);
      n_checks++;
      if (st !== 1 || wes !== 0) begin
         n_fail++;
         $display("FAIL cancel_commit: stall %0d we %0d want 1 0", st, wes);
      end
      n_checks++;
      if (Mem_ReadData !== 32'hCAFEABCD) begin
         n_fail++;
         $display("FAIL cancel_rdhold: got %h want cafeabcd", Mem_ReadData);
      end
      do_access(32'h48, 32'h48, 1'b1, 1'b1, 4'b0000, 32'hFFFFFFFF, st, wes, ovl, bes);
      n_checks++;
      if (st !== 1 || wes !== 0) begin
         n_fail++;
         $display("FAIL cancel_nobytes: stall %0d we %0d want 1 0", st, wes);
      end
      do_access(32'h48, 32'h48, 1'b0, 1'b0, 4'd0, 32'd0, st, wes, ovl, bes);
      n_checks++;
      if (Mem_ReadData !== 32'h11112222) begin
         n_fail++;
         $display("FAIL cancel_array: got %h want 11112222", Mem_ReadData);
      end
   endtask

   task automatic test_back_to_back();
      int st1, st2, st3, w, o1, o2, o3;
      logic [3:0] bes;
      logic [31:0] first_rd;
      do_access(32'h40, 32'h40, 1'b0, 1'b0, 4'd0, 32'd0, st1, w, o1, bes);
      first_rd = Mem_ReadData;
      do_access(32'h4C, 32'h4C, 1'b1, 1'b1, 4'b1111, 32'h55AA55AA, st2, w, o2, bes);
      do_access(32'h4C, 32'h4C, 1'b0, 1'b0, 4'd0, 32'd0, st3, w, o3, bes);
      n_checks++;
      if (st1 !== 2 || st2 !== 3 || st3 !== 2) begin
         n_fail++;
         $display("FAIL b2b_stalls: %0d %0d %0d want 2 3 2", st1, st2, st3);
      end
      n_checks++;
      if (o1 + o2 + o3 !== 0) begin
         n_fail++;
         $display("FAIL b2b_oe_we: overlap %0d want 0", o1 + o2 + o3);
      end
      n_checks++;
      if (first_rd !== 32'hDEADBEEF || Mem_ReadData !== 32'h55AA55AA) begin
         n_fail++;
         $display("FAIL b2b_data: %h %h want deadbeef 55aa55aa", first_rd, Mem_ReadData);
      end
   endtask

   task automatic test_proto();
      int st, wes, ovl;
      logic [3:0] bes;
      apply_reset();
      Mem_EarlyStrobe  = 1'b1;
      Mem_EarlyAddress = 32'h40;
      Mem_EarlyWrite   = 1'b0;
      @(negedge clock);
      Mem_EarlyAddress = 32'h80;
      Mem_EarlyWrite   = 1'b1;
      Mem_Address      = 32'h40;
      st = Mem_Stall ? 1 : 0;
      @(negedge clock);
      Mem_EarlyStrobe = 1'b0;
      while (Mem_Stall && st < 32) begin
         st++;
         @(negedge clock);
      end
      n_checks++;
      if (proto_err !== 2'b01) begin
         n_fail++;
         $display("FAIL proto_busy: got %b want 01", proto_err);
      end
      n_checks++;
      if (st !== 2 || Mem_ReadData !== 32'hDEADBEEF || sram_addr !== 18'h10) begin
         n_fail++;
         $display("FAIL proto_read: stall %0d rd %h addr %h want 2 deadbeef 10", st, Mem_ReadData, sram_addr);
      end
      do_access(32'h40, 32'h80, 1'b0, 1'b0, 4'd0, 32'd0, st, wes, ovl, bes);
      n_checks++;
      if (proto_err !== 2'b11 || Mem_ReadData !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL proto_addr: err %b rd %h want 11 deadbeef", proto_err, Mem_ReadData);
      end
   endtask

   task automatic test_reset_mid_write();
      Mem_EarlyStrobe  = 1'b1;
      Mem_EarlyAddress = 32'h44;
      Mem_EarlyWrite   = 1'b1;
      @(negedge clock);
      Mem_EarlyStrobe = 1'b0;
      Mem_Address     = 32'h44;
      Mem_Write       = 1'b1;
      Mem_ByteSelect  = 4'b1111;
      Mem_WriteData   = 32'h0;
      @(negedge clock);
      n_checks++;
      if (sram_we !== 1'b1 || Mem_Stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pulse: we %b stall %b want 1 1", sram_we, Mem_Stall);
      end
      reset = 1'b1;
      @(negedge clock);
      reset          = 1'b0;
      Mem_Write      = 1'b0;
      Mem_ByteSelect = 4'd0;
      n_checks++;
      if ({sram_we, sram_ce, sram_oe, Mem_Stall} !== 4'b0000 || proto_err !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_mid: we ce oe stall %b err %b want 0000 00",
                  {sram_we, sram_ce, sram_oe, Mem_Stall}, proto_err);
      end
      n_checks++;
      if (Mem_ReadData !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_rdata: got %h want 0", Mem_ReadData);
      end
   endtask

   task automatic test_alias();
      int st, wes, ovl;
      logic [3:0] bes;
      do_access(32'hFFF00040, 32'h40, 1'b0, 1'b0, 4'd0, 32'd0, st, wes, ovl, bes);
      n_checks++;
      if (sram_addr !== 18'h10 || Mem_ReadData !== 32'hDEADBEEF || proto_err !== 2'b00) begin
         n_fail++;
         $display("FAIL alias: addr %h rd %h err %b want 10 deadbeef 00", sram_addr, Mem_ReadData, proto_err);
      end
   endtask

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      reset            = 1'b1;
      pl_en            = 1'b0;
      pl_idx           = 8'd0;
      pl_val           = 32'd0;
      Mem_EarlyStrobe  = 1'b0;
      Mem_EarlyAddress = 32'd0;
      Mem_EarlyWrite   = 1'b0;
      Mem_Address      = 32'd0;
      Mem_Write        = 1'b0;
      Mem_ByteSelect   = 4'd0;
      Mem_WriteData    = 32'd0;
      @(negedge clock);
      test_reset();
      test_read();
      test_write();
      test_cancelled();
      test_back_to_back();
      test_proto();
      test_reset_mid_write();
      test_alias();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the CPU data bus (early-strobe/stall protocol). It accepts the one-cycle-early address and strobe, then completes the access against a 32-bit asynchronous SRAM-style array with programmable wait states. While the access is outstanding it holds Mem_Stall high and returns registered read data. It sits between the CPU data memory controller and the on-board data SRAM.

Parameters:
ADDR_BITS, 18, SRAM word-address width; sram_addr = address[ADDR_BITS+1:2]
RD_WAIT, 1, extra SRAM read cycles before sampling sram_rdata (0..15)
WR_WAIT, 1, extra cycles sram_we is held beyond the first (0..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
Mem_EarlyStrobe  in  1  new access enters M stage next cycle
Mem_EarlyAddress  in  32  address for that access, valid with strobe
Mem_EarlyWrite  in  1  access is a write, valid with strobe
Mem_Address  in  32  M-stage address
Mem_Write  in  1  M-stage write commit (0 = cancelled store)
Mem_ByteSelect  in  4  M-stage byte lanes, bit3 = [31:24]
Mem_WriteData  in  32  M-stage write data
Mem_ReadData  out  32  read data, valid in the cycle Mem_Stall falls after a read
Mem_Stall  out  1  access outstanding
sram_addr  out  ADDR_BITS  word address (registered)
sram_wdata  out  32  write data (registered)
sram_rdata  in  32  array read data
sram_ce  out  1  chip enable (registered)
sram_oe  out  1  output enable (registered)
sram_we  out  1  write strobe (registered)
sram_be  out  4  byte enables (registered)
proto_err  out  2  sticky: [0] strobe while busy, [1] M address mismatch

Behaviour:
- Reset: state IDLE, counter 0, Mem_Stall 0, Mem_ReadData 0, all sram_* outputs 0, proto_err 0. Reset mid-access abandons it; sram_ce/oe/we are 0 after the next edge.
- States: IDLE, RD, WR_SETUP, WR_PULSE, DONE. Mem_Stall = state in {RD, WR_SETUP, WR_PULSE}.
- IDLE/DONE + Mem_EarlyStrobe:
  - latch sram_addr from Mem_EarlyAddress.
  - If Mem_EarlyWrite: go to WR_SETUP.
  - Else: go to RD with cnt = RD_WAIT, sram_ce = 1, sram_oe = 1.
- IDLE/DONE without strobe: go to IDLE; drop sram_ce/oe/we.
- RD: if cnt != 0, decrement. If cnt == 0, load Mem_ReadData from sram_rdata, drop ce/oe, go to DONE. A read stalls for RD_WAIT+1 cycles.
- WR_SETUP (first M cycle of a write):
  - If Mem_Write & (Mem_ByteSelect != 0): register sram_wdata and sram_be, set sram_ce = 1 and sram_we = 1, cnt = WR_WAIT, go to WR_PULSE.
  - Otherwise (cancelled store): go to DONE with no SRAM write; stall is 1 cycle.
- WR_PULSE: if cnt != 0, decrement. If cnt == 0, drop we/ce/be, go to DONE. A write stalls for WR_WAIT+2 cycles.
- Address check: in the first M cycle of any access (RD entry cycle or WR_SETUP), Mem_Address[ADDR_BITS+1:2] != latched sram_addr sets proto_err[1]. The access still completes.
- Strobe while state is RD, WR_SETUP or WR_PULSE is a protocol violation: ignore it and set proto_err[0].
- Back-to-back: a strobe in DONE (the cycle Mem_Stall is low) starts the next access at that edge with no idle cycle. A read following a write has sram_we = 0 before sram_oe rises.
- Mem_ReadData holds its value until the next read completes; writes do not change it.
- Address bits above ADDR_BITS+1 are ignored (aliasing).

Decomposition:
- Shared parameters include holds the state encodings (3-bit localparams) and the proto_err bit indices.
- No sub-module is needed. The wait counter is a 4-bit down-counter inline.

Test Plan:
- RD_WAIT=1, SRAM word 0x10 = 0xDEADBEEF; strobe with read at address 0x40 -> Mem_Stall high 2 cycles, then low with Mem_ReadData = 0xDEADBEEF; sram_addr = 0x10.
- WR_WAIT=1; strobe with write at address 0x44, then Mem_Write = 1, ByteSelect = 4'b0011, WriteData = 0x1234ABCD -> sram_we high 2 cycles, sram_be = 0011, stall 3 cycles; read back 0xXXXXABCD (upper half unchanged).
- Cancelled SC: strobe with write, then Mem_Write = 0 -> sram_we never rises, stall exactly 1 cycle, array unchanged.
- Back-to-back: read A, with the next strobe (write B) in DONE -> write starts at the next edge; no cycle where both sram_oe and sram_we are 1.
- Strobe during RD -> proto_err = 2'b01 and the current read completes normally. Mem_Address differs from early address -> proto_err[1] set.
- Reset asserted during WR_PULSE -> next cycle sram_we = 0, Mem_Stall = 0, state IDLE, proto_err = 0.
